// File: rtl/predictor_pkg.sv
// rtl/predictor_pkg.sv - shared types and counter helpers for the gshare predictor
// Purpose: FSM state encoding plus saturating-counter step and init-value helpers.
//          Counter helpers work on a 4-bit container; callers truncate to CTR_WIDTH.
package predictor_pkg;

   typedef enum logic {
      PRED_INIT = 1'b0,
      PRED_RUN  = 1'b1
   } pred_state_t;

   // Saturating step: +1 clamped at 2**width-1, -1 clamped at 0.
   function automatic logic [3:0] ctr_next(input logic [3:0] ctr, input logic taken, input int width);
      logic [3:0] max_val;
      max_val = 4'((1 << width) - 1);
      if (taken) begin
         return (ctr >= max_val) ? max_val : ctr + 4'd1;
      end
      return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
   endfunction

   // Weakly not-taken: 2**(width-1)-1.
   function automatic logic [3:0] ctr_init(input int width);
      return 4'((1 << (width - 1)) - 1);
   endfunction

endpackage

// File: rtl/pht_table.sv
// rtl/pht_table.sv - pattern history table of saturating counters
// Purpose: counter array with one combinational read port and one write port.
//          The write port either stores the init value or applies a saturating
//          step to the addressed counter (read-modify-write inside the table).
// Ports:
//   i_clk       clock
//   i_wr_en     perform a write this cycle
//   i_wr_idx    write address
//   i_wr_init   1 = write init value, 0 = saturating step
//   i_wr_taken  direction used for the saturating step
//   i_rd_idx    read address (registered lookup index from the top)
//   o_rd_ctr    counter at i_rd_idx
module pht_table
   import predictor_pkg::*;
#(
   parameter int INDEX_WIDTH = 12,
   parameter int CTR_WIDTH   = 2
) (
   input  logic                   i_clk,
   input  logic                   i_wr_en,
   input  logic [INDEX_WIDTH-1:0] i_wr_idx,
   input  logic                   i_wr_init,
   input  logic                   i_wr_taken,
   input  logic [INDEX_WIDTH-1:0] i_rd_idx,
   output logic [CTR_WIDTH-1:0]   o_rd_ctr
);

   localparam int DEPTH = 1 << INDEX_WIDTH;

   // No reset: contents are cleared by the init sweep in the top.
   logic [CTR_WIDTH-1:0] r_mem [DEPTH];

   logic [3:0]           w_cur;
   logic [CTR_WIDTH-1:0] w_wdata;

   always_comb begin
      w_cur   = 4'(r_mem[i_wr_idx]);
      w_wdata = i_wr_init ? CTR_WIDTH'(ctr_init(CTR_WIDTH))
                          : CTR_WIDTH'(ctr_next(w_cur, i_wr_taken, CTR_WIDTH));
   end

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= w_wdata;
      end
   end

   assign o_rd_ctr = r_mem[i_rd_idx];

endmodule

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare / bimodal branch direction predictor
// Purpose: FSM (init sweep then run), speculative global history, index hashing,
//          commit-time counter update and mispredict history recovery.
// Ports:
//   clockIn, resetIn        clock, async active-high reset
//   readyOut                high once the table init sweep is complete
//   lookupValid, instrAddr  fetch lookup request
//   jump, predHist          prediction and history snapshot of the last lookup
//   specValid, specTaken    speculative history shift from fetch
//   updateValid, updateInstr, updateHist, taken, mispredict
//                           commit update / recovery from the ROB
module gshare_predictor
   import predictor_pkg::*;
#(
   parameter int INDEX_WIDTH = 12,
   parameter int HIST_WIDTH  = 8,
   parameter int CTR_WIDTH   = 2,
   parameter int USE_GLOBAL  = 1
) (
   input  logic                  clockIn,
   input  logic                  resetIn,
   output logic                  readyOut,
   input  logic                  lookupValid,
   input  logic [31:0]           instrAddr,
   output logic                  jump,
   output logic [HIST_WIDTH-1:0] predHist,
   input  logic                  specValid,
   input  logic                  specTaken,
   input  logic                  updateValid,
   input  logic [31:0]           updateInstr,
   input  logic [HIST_WIDTH-1:0] updateHist,
   input  logic                  taken,
   input  logic                  mispredict
);

   localparam logic [INDEX_WIDTH-1:0] IDX_ONE = 1;

   pred_state_t            r_state;
   pred_state_t            w_state_next;
   logic [INDEX_WIDTH-1:0] r_init_idx;
   logic [HIST_WIDTH-1:0]  r_ghr;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic [HIST_WIDTH-1:0]  r_pred_hist;

   logic [INDEX_WIDTH-1:0] w_lookup_idx;
   logic [INDEX_WIDTH-1:0] w_update_idx;
   logic [HIST_WIDTH-1:0]  w_ghr_shift;
   logic [HIST_WIDTH-1:0]  w_ghr_recover;
   logic                   w_run;
   logic                   w_wr_en;
   logic [INDEX_WIDTH-1:0] w_wr_idx;
   logic                   w_wr_init;
   logic [CTR_WIDTH-1:0]   w_ctr;
   logic                   w_unused_addr;

   assign w_run = (r_state == PRED_RUN);

   // History is zero-extended to the index width before hashing.
   always_comb begin
      w_lookup_idx = instrAddr[INDEX_WIDTH+1:2];
      w_update_idx = updateInstr[INDEX_WIDTH+1:2];
      if (USE_GLOBAL != 0) begin
         w_lookup_idx = instrAddr[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(r_ghr);
         w_update_idx = updateInstr[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(updateHist);
      end
   end

   // Newest bit enters at the LSB; the cast drops the oldest bit.
   assign w_ghr_shift   = HIST_WIDTH'({r_ghr, specTaken});
   assign w_ghr_recover = HIST_WIDTH'({updateHist, taken});

   assign w_unused_addr = ^{instrAddr[31:INDEX_WIDTH+2], instrAddr[1:0],
                            updateInstr[31:INDEX_WIDTH+2], updateInstr[1:0]};

   // Next state and write-port arbitration: init writer owns the port in INIT.
   always_comb begin
      w_state_next = r_state;
      w_wr_en      = 1'b0;
      w_wr_idx     = r_init_idx;
      w_wr_init    = 1'b1;
      case (r_state)
         PRED_INIT: begin
            w_wr_en = 1'b1;
            if (r_init_idx == '1) begin
               w_state_next = PRED_RUN;
            end
         end
         PRED_RUN: begin
            if (updateValid) begin
               w_wr_en   = 1'b1;
               w_wr_idx  = w_update_idx;
               w_wr_init = 1'b0;
            end
         end
         default: w_state_next = PRED_INIT;
      endcase
   end

   always_ff @(posedge clockIn or posedge resetIn) begin
      if (resetIn) begin
         r_state     <= PRED_INIT;
         r_init_idx  <= '0;
         r_ghr       <= '0;
         r_idx       <= '0;
         r_pred_hist <= '0;
      end else begin
         r_state <= w_state_next;
         if (!w_run) begin
            r_init_idx <= r_init_idx + IDX_ONE;
         end else begin
            if (lookupValid) begin
               r_idx       <= w_lookup_idx;
               r_pred_hist <= r_ghr;
            end
            // Recovery takes priority over a speculative shift.
            if (updateValid && mispredict) begin
               r_ghr <= w_ghr_recover;
            end else if (specValid) begin
               r_ghr <= w_ghr_shift;
            end
         end
      end
   end

   pht_table #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .CTR_WIDTH  (CTR_WIDTH)
   ) u_pht (
      .i_clk     (clockIn),
      .i_wr_en   (w_wr_en),
      .i_wr_idx  (w_wr_idx),
      .i_wr_init (w_wr_init),
      .i_wr_taken(taken),
      .i_rd_idx  (r_idx),
      .o_rd_ctr  (w_ctr)
   );

   // Read is combinational off the registered index, so a same-edge update is visible.
   assign readyOut = w_run;
   assign jump     = w_run & w_ctr[CTR_WIDTH-1];
   assign predHist = r_pred_hist;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - scoreboard bench for gshare and bimodal predictor instances
module tb_gshare_predictor;

   localparam int IW    = 4;
   localparam int HW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lookupValid = 1'b0;
   logic [31:0]   instrAddr = '0;
   logic          specValid = 1'b0;
   logic          specTaken = 1'b0;
   logic          updateValid = 1'b0;
   logic [31:0]   updateInstr = '0;
   logic [HW-1:0] updateHist = '0;
   logic          taken = 1'b0;
   logic          mispredict = 1'b0;

   logic          ready_g, jump_g, ready_b, jump_b;
   logic [HW-1:0] hist_g, hist_b;

   always #5 clk = ~clk;

   gshare_predictor #(.INDEX_WIDTH(IW), .HIST_WIDTH(HW), .CTR_WIDTH(2), .USE_GLOBAL(1)) dut_g (
      .clockIn(clk), .resetIn(rst), .readyOut(ready_g),
      .lookupValid(lookupValid), .instrAddr(instrAddr), .jump(jump_g), .predHist(hist_g),
      .specValid(specValid), .specTaken(specTaken),
      .updateValid(updateValid), .updateInstr(updateInstr), .updateHist(updateHist),
      .taken(taken), .mispredict(mispredict));

   gshare_predictor #(.INDEX_WIDTH(IW), .HIST_WIDTH(HW), .CTR_WIDTH(2), .USE_GLOBAL(0)) dut_b (
      .clockIn(clk), .resetIn(rst), .readyOut(ready_b),
      .lookupValid(lookupValid), .instrAddr(instrAddr), .jump(jump_b), .predHist(hist_b),
      .specValid(specValid), .specTaken(specTaken),
      .updateValid(updateValid), .updateInstr(updateInstr), .updateHist(updateHist),
      .taken(taken), .mispredict(mispredict));

   typedef struct {
      int jg;
      int jb;
      int hist;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   pht_g[DEPTH];
   int   pht_b[DEPTH];
   int   ghr;
   int   init_left;
   bit   pending;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int sat(input int c, input bit t);
      if (t) return (c >= 3) ? 3 : c + 1;
      return (c <= 0) ? 0 : c - 1;
   endfunction

   function automatic int idx_of(input logic [31:0] addr, input int hist, input bit use_g);
      int base;
      base = int'((addr >> 2) % 32'(DEPTH));
      return use_g ? (base ^ hist) : base;
   endfunction

   task automatic model_reset();
      foreach (pht_g[i]) begin
         pht_g[i] = 1;
         pht_b[i] = 1;
      end
      ghr       = 0;
      init_left = DEPTH;
      sb_q.delete();
      pending   = 1'b0;
   endtask

   task automatic clear_inputs();
      lookupValid = 1'b0; instrAddr = '0; specValid = 1'b0; specTaken = 1'b0;
      updateValid = 1'b0; updateInstr = '0; updateHist = '0; taken = 1'b0; mispredict = 1'b0;
   endtask

   // Applies the current inputs to the model for the coming edge, then advances one cycle.
   task automatic step();
      exp_t e;
      if (init_left == 0) begin
         if (updateValid) begin
            pht_g[idx_of(updateInstr, int'(updateHist), 1'b1)] =
               sat(pht_g[idx_of(updateInstr, int'(updateHist), 1'b1)], taken);
            pht_b[idx_of(updateInstr, int'(updateHist), 1'b0)] =
               sat(pht_b[idx_of(updateInstr, int'(updateHist), 1'b0)], taken);
         end
         if (lookupValid) begin
            e.jg   = (pht_g[idx_of(instrAddr, ghr, 1'b1)] >= 2) ? 1 : 0;
            e.jb   = (pht_b[idx_of(instrAddr, ghr, 1'b0)] >= 2) ? 1 : 0;
            e.hist = ghr;
            sb_q.push_back(e);
         end
         if (updateValid && mispredict) ghr = (int'(updateHist) * 2 + int'(taken)) % DEPTH;
         else if (specValid) ghr = (ghr * 2 + int'(specTaken)) % DEPTH;
      end
      @(posedge clk);
      #1;
      if (init_left > 0) init_left--;
      clear_inputs();
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      model_reset();
      repeat (cycles) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] a);
      lookupValid = 1'b1;
      instrAddr   = a;
      step();
   endtask

   task automatic update(input logic [31:0] a, input logic [HW-1:0] h, input logic t);
      updateValid = 1'b1;
      updateInstr = a;
      updateHist  = h;
      taken       = t;
      step();
   endtask

   task automatic spec(input logic t);
      specValid = 1'b1;
      specTaken = t;
      step();
   endtask

   // Monitor: checks ready/gating every cycle and retires one expected lookup result.
   always @(negedge clk) begin
      exp_t e;
      check("ready_g", int'(ready_g), (init_left == 0) ? 1 : 0);
      check("ready_b", int'(ready_b), (init_left == 0) ? 1 : 0);
      if (init_left != 0) begin
         check("jump_gated_g", int'(jump_g), 0);
         check("jump_gated_b", int'(jump_b), 0);
      end
      if (pending) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("jump_g", int'(jump_g), e.jg);
            check("jump_b", int'(jump_b), e.jb);
            check("hist_g", int'(hist_g), e.hist);
            check("hist_b", int'(hist_b), e.hist);
         end
      end
      pending = lookupValid && (init_left == 0);
   end

   initial begin
      clear_inputs();
      do_reset(2);
      check("rst_ready", int'(ready_g), 0);
      check("rst_jump", int'(jump_g), 0);
      check("rst_hist", int'(hist_g), 0);

      // Lookups during the sweep are ignored; reset again at cycle 7.
      repeat (7) lookup(32'h40);
      do_reset(1);

      // Update during INIT must be dropped.
      update(32'h40, 4'h0, 1'b1);
      while (init_left > 0) step();
      lookup(32'h40);

      // Bimodal-style training (history 0): 01 -> 10 -> 11 -> 11, then back down.
      repeat (3) update(32'h40, 4'h0, 1'b1);
      lookup(32'h40);
      repeat (2) update(32'h40, 4'h0, 1'b0);
      lookup(32'h40);

      // Train gshare entry 0 ^ 4'b1011, then build that history speculatively.
      repeat (2) update(32'h40, 4'hB, 1'b1);
      spec(1'b1); spec(1'b0); spec(1'b1); spec(1'b1);
      lookup(32'h40);

      // Recovery beats a same-cycle speculative shift: GHR becomes 4'b0100.
      specValid = 1'b1; specTaken = 1'b1;
      updateValid = 1'b1; mispredict = 1'b1; updateInstr = 32'h88; updateHist = 4'h2; taken = 1'b0;
      step();
      lookup(32'h20);

      // Same-cycle lookup and update to one fresh entry: 01 -> 10 seen immediately.
      lookupValid = 1'b1; instrAddr = 32'h14;
      updateValid = 1'b1; updateInstr = 32'h14; updateHist = 4'h4; taken = 1'b1;
      step();
      step();

      // Randomised traffic against the model.
      repeat (400) begin
         lookupValid = 1'($urandom);
         instrAddr   = $urandom;
         specValid   = 1'($urandom);
         specTaken   = 1'($urandom);
         updateValid = 1'($urandom);
         updateInstr = $urandom;
         updateHist  = 4'($urandom);
         taken       = 1'($urandom);
         mispredict  = ($urandom_range(0, 3) == 0);
         step();
      end

      // Reset mid-run restores every entry to weakly not-taken.
      do_reset(1);
      while (init_left > 0) step();
      for (int i = 0; i < DEPTH; i++) lookup(32'(i * 4));
      step();
      step();
      check("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised successor to the per-address 2-bit branch predictor. It indexes a pattern history table (PHT) of saturating counters with the instruction address, optionally XORed with a speculative global history register (GHR). It checkpoints and restores history on mispredict, and clears its table with an internal init sweep rather than a reset fan-out. It sits between the icache/fetch stage (lookup, speculative history) and the Reorder Buffer (commit update, mispredict recovery).

## Interface
- INDEX_WIDTH, 12: PHT index width; table depth 2**INDEX_WIDTH.
- HIST_WIDTH, 8: GHR width; legal range 1..INDEX_WIDTH.
- CTR_WIDTH, 2: counter width; legal range 2..4.
- USE_GLOBAL, 1: 1 = gshare index, 0 = bimodal (history ignored for indexing; still tracked).
- clockIn  input  1  clock.
- resetIn  input  1  reset, asynchronous, active-high.
- readyOut  output  1  high once the init sweep is complete.
- lookupValid  input  1  fetch presents instrAddr this cycle.
- instrAddr  input  32  fetch address.
- jump  output  1  prediction for the last accepted lookup.
- predHist  output  HIST_WIDTH  GHR snapshot used by that lookup; the ROB carries it with the branch.
- specValid  input  1  fetch has identified a branch; shift specTaken into the GHR.
- specTaken  input  1  predicted direction being shifted.
- updateValid  input  1  ROB commits a resolved branch.
- updateInstr  input  32  committed branch address.
- updateHist  input  HIST_WIDTH  predHist that was recorded for that branch.
- taken  input  1  resolved direction.
- mispredict  input  1  qualifies updateValid; restore the GHR.

## Operation
- Counters use plain saturating arithmetic: taken gives +1 clamped at 2**CTR_WIDTH-1; not taken gives -1 clamped at 0. The prediction is the counter MSB.
- Init value is 2**(CTR_WIDTH-1)-1 (weakly not-taken; 2'b01 for CTR_WIDTH=2).
- Lookup index: instrAddr[INDEX_WIDTH+1:2] XOR zero-extended GHR when USE_GLOBAL=1; instrAddr[INDEX_WIDTH+1:2] alone otherwise. The GHR value used is the value before any shift in the same cycle.
- Update index: updateInstr[INDEX_WIDTH+1:2] XOR zero-extended updateHist, with the same USE_GLOBAL rule.
- GHR shift: GHR <= {GHR[HIST_WIDTH-2:0], specTaken}, with the newest bit at the LSB.
- Recovery: when updateValid && mispredict, GHR <= {updateHist[HIST_WIDTH-2:0], taken}. This overrides specValid in the same cycle. mispredict without updateValid is ignored.
- State machine:
  - INIT: an index counter writes the init value to one entry per cycle, entry 0 up to 2**INDEX_WIDTH-1. After the last write, go to RUN.
  - RUN: readyOut=1. Lookups, updates and history operations are live.
- In INIT, lookupValid, specValid and updateValid are ignored (updates are dropped and not queued).

## Timing
- Reset values: state=INIT, init counter=0, GHR=0, registered index=0, readyOut=0, jump=0, predHist=0.
- Reset asserted mid-sweep or mid-run restarts the sweep from entry 0.
- Init takes 2**INDEX_WIDTH cycles: 4096 at defaults. readyOut rises on the edge that writes the last entry.
- Lookup latency is 1 cycle:
  - The index and predHist are registered on the edge where lookupValid is high.
  - jump is combinational from the registered index and current table contents.
  - Without a new lookup, jump and predHist hold.
- Update write takes effect on the edge where updateValid is high. A lookup registered at that same edge to the same entry sees the new value.
- Lookup and update may occur in the same cycle. At most one PHT write per cycle.
- jump is forced to 0 while readyOut=0.

## Structure
- Shared package predictor_pkg holds:
  - function ctr_next(ctr, taken) for saturating step;
  - function ctr_init;
  - state encoding (PRED_INIT, PRED_RUN).
- Sub-module pht_table holds the counter array with one read port (registered index) and one write port. It is shared by the init writer and the update writer, with the init writer muxed in during INIT.
- gshare_predictor holds the FSM, GHR, index hashing and recovery.

## Test plan
- Reset, then idle at INDEX_WIDTH=4 → readyOut low for 16 cycles, then high. A lookup to any address → jump=0. Assert reset mid-sweep at cycle 7 → readyOut low for another 16 cycles.
- USE_GLOBAL=0, addr 0x40: three taken updates, then lookup → counter 01→10→11→11, jump=1. Two not-taken updates → jump=0.
- updateValid during INIT with taken=1 at 0x40 → no effect; after ready, lookup 0x40 → jump=0.
- USE_GLOBAL=1, HIST_WIDTH=4: specValid with specTaken sequence 1,0,1,1 → predHist on the next lookup = 4'b1011. The lookup index equals addr bits XOR 4'b1011.
- GHR=4'b1011, same cycle: specValid=1 and updateValid=1, mispredict=1, updateHist=4'b0010, taken=0 → GHR=4'b0100 (recovery wins).
- Lookup and update to the same index in one cycle (taken, counter 01) → jump in the next cycle = 1.
